// File: rtl/y86_execute_pipe.sv
// Y86-64 PIPE execute stage: ALU operand/function selection, condition-code
// register, branch/cmov condition evaluation and the E->M pipeline register.
module y86_execute_pipe #(
    parameter int WIDTH      = 64,
    parameter int STACK_STEP = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       E_stat,
    input  logic [3:0]       E_icode,
    input  logic [3:0]       E_ifun,
    input  logic [WIDTH-1:0] E_valA,
    input  logic [WIDTH-1:0] E_valB,
    input  logic [WIDTH-1:0] E_valC,
    input  logic [3:0]       E_dstE,
    input  logic [3:0]       E_dstM,
    input  logic             set_cc_block,
    input  logic             M_stall,
    input  logic             M_bubble,
    output logic [WIDTH-1:0] e_valE,
    output logic [3:0]       e_dstE,
    output logic             e_cnd,
    output logic [2:0]       cc,
    output logic [3:0]       M_stat,
    output logic [3:0]       M_icode,
    output logic             M_cnd,
    output logic [WIDTH-1:0] M_valE,
    output logic [WIDTH-1:0] M_valA,
    output logic [3:0]       M_dstE,
    output logic [3:0]       M_dstM
);

    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;
    localparam logic [3:0] S_AOK    = 4'h1;
    localparam logic [3:0] R_NONE   = 4'hF;

    localparam logic [WIDTH-1:0] STEP = WIDTH'(STACK_STEP);

    logic [WIDTH-1:0] alu_a, alu_b;
    logic [3:0]       alu_fun;
    logic             zf, sf, of;
    logic             set_cc;
    logic [2:0]       cc_q, cc_d;

    logic [3:0]       m_stat_q, m_icode_q, m_dste_q, m_dstm_q;
    logic             m_cnd_q;
    logic [WIDTH-1:0] m_vale_q, m_vala_q;

    // ALU operand and function selection from the instruction code
    always_comb begin
        alu_a   = '0;
        alu_b   = '0;
        alu_fun = 4'h0;
        case (E_icode)
            I_RRMOVQ, I_OPQ:             alu_a = E_valA;
            I_IRMOVQ, I_RMMOVQ, I_MRMOVQ: alu_a = E_valC;
            I_CALL, I_PUSHQ:             alu_a = '0 - STEP;
            I_RET, I_POPQ:               alu_a = STEP;
            default:                     alu_a = '0;
        endcase
        case (E_icode)
            I_RMMOVQ, I_MRMOVQ, I_OPQ,
            I_CALL, I_RET, I_PUSHQ, I_POPQ: alu_b = E_valB;
            default:                        alu_b = '0;
        endcase
        if (E_icode == I_OPQ) alu_fun = E_ifun;
    end

    // ALU result and the flags it would produce
    always_comb begin
        e_valE = '0;
        of     = 1'b0;
        case (alu_fun)
            4'h0: begin
                e_valE = alu_b + alu_a;
                of = (alu_a[WIDTH-1] == alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_a[WIDTH-1]);
            end
            4'h1: begin
                e_valE = alu_b - alu_a;
                of = (alu_a[WIDTH-1] != alu_b[WIDTH-1]) && (e_valE[WIDTH-1] != alu_b[WIDTH-1]);
            end
            4'h2:    e_valE = alu_b & alu_a;
            4'h3:    e_valE = alu_b ^ alu_a;
            default: e_valE = '0;
        endcase
        zf = (e_valE == '0);
        sf = e_valE[WIDTH-1];
    end

    // Condition evaluation against the architectural flags and cmov dest squash
    always_comb begin
        logic zf_q, sf_q, of_q;
        {zf_q, sf_q, of_q} = cc_q;
        case (E_ifun)
            4'h0:    e_cnd = 1'b1;
            4'h1:    e_cnd = (sf_q ^ of_q) | zf_q;
            4'h2:    e_cnd = sf_q ^ of_q;
            4'h3:    e_cnd = zf_q;
            4'h4:    e_cnd = !zf_q;
            4'h5:    e_cnd = !(sf_q ^ of_q);
            4'h6:    e_cnd = !(sf_q ^ of_q) && !zf_q;
            default: e_cnd = 1'b0;
        endcase
        e_dstE = ((E_icode == I_RRMOVQ) && !e_cnd) ? R_NONE : E_dstE;
    end

    // Flags commit only for a valid arithmetic op that actually advances into M
    always_comb begin
        set_cc = (E_icode == I_OPQ) && (E_ifun <= 4'h3) && (E_stat == S_AOK) &&
                 !set_cc_block && !M_stall && !M_bubble;
        cc_d   = set_cc ? {zf, sf, of} : cc_q;
    end

    // Condition-code register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) cc_q <= 3'b100;
        else     cc_q <= cc_d;
    end

    // E->M pipeline register; stall takes priority over bubble
    always_ff @(posedge clk or posedge rst) begin
        if (rst || (M_bubble && !M_stall)) begin
            m_stat_q  <= S_AOK;
            m_icode_q <= I_NOP;
            m_cnd_q   <= 1'b0;
            m_vale_q  <= '0;
            m_vala_q  <= '0;
            m_dste_q  <= R_NONE;
            m_dstm_q  <= R_NONE;
        end else if (!M_stall) begin
            m_stat_q  <= E_stat;
            m_icode_q <= E_icode;
            m_cnd_q   <= e_cnd;
            m_vale_q  <= e_valE;
            m_vala_q  <= E_valA;
            m_dste_q  <= e_dstE;
            m_dstm_q  <= E_dstM;
        end
    end

    assign cc      = cc_q;
    assign M_stat  = m_stat_q;
    assign M_icode = m_icode_q;
    assign M_cnd   = m_cnd_q;
    assign M_valE  = m_vale_q;
    assign M_valA  = m_vala_q;
    assign M_dstE  = m_dste_q;
    assign M_dstM  = m_dstm_q;

endmodule

// File: tb/tb_y86_execute_pipe.sv
// Bench for y86_execute_pipe: instruction-level reference model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_y86_execute_pipe;

    logic        clk, rst;
    logic [3:0]  E_stat, E_icode, E_ifun, E_dstE, E_dstM;
    logic [63:0] E_valA, E_valB, E_valC;
    logic        set_cc_block, M_stall, M_bubble;

    logic [63:0] e_valE, M_valE, M_valA;
    logic [3:0]  e_dstE, M_stat, M_icode, M_dstE, M_dstM;
    logic        e_cnd, M_cnd;
    logic [2:0]  cc;

    logic [31:0] n_valE, nM_valE, nM_valA;
    logic [3:0]  n_dstE, nM_stat, nM_icode, nM_dstE, nM_dstM;
    logic        n_cnd, nM_cnd;
    logic [2:0]  n_cc;

    int n_checks = 0;
    int n_fail   = 0;
    bit run      = 0;

    y86_execute_pipe #(.WIDTH(64), .STACK_STEP(8)) dut (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC), .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc_block(set_cc_block), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(e_valE), .e_dstE(e_dstE), .e_cnd(e_cnd), .cc(cc),
        .M_stat(M_stat), .M_icode(M_icode), .M_cnd(M_cnd), .M_valE(M_valE),
        .M_valA(M_valA), .M_dstE(M_dstE), .M_dstM(M_dstM)
    );

    y86_execute_pipe #(.WIDTH(32), .STACK_STEP(4)) dut32 (
        .clk(clk), .rst(rst), .E_stat(E_stat), .E_icode(E_icode), .E_ifun(E_ifun),
        .E_valA(E_valA[31:0]), .E_valB(E_valB[31:0]), .E_valC(E_valC[31:0]),
        .E_dstE(E_dstE), .E_dstM(E_dstM),
        .set_cc_block(set_cc_block), .M_stall(M_stall), .M_bubble(M_bubble),
        .e_valE(n_valE), .e_dstE(n_dstE), .e_cnd(n_cnd), .cc(n_cc),
        .M_stat(nM_stat), .M_icode(nM_icode), .M_cnd(nM_cnd), .M_valE(nM_valE),
        .M_valA(nM_valA), .M_dstE(nM_dstE), .M_dstM(nM_dstM)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [2:0]  mcc;
    logic [3:0]  mstat, micode, mdstE, mdstM;
    logic        mcnd;
    logic [63:0] mvalE, mvalA;

    // Instruction semantics: result, condition, destination and flag effect
    function automatic void model_exec(output logic [63:0] v, output logic c,
                                       output logic [3:0] d, output logic [2:0] flags,
                                       output logic upd);
        logic signed [127:0] sa, sb, tr;
        logic zf, sf, of;
        of = 1'b0;
        v  = 64'd0;
        case (E_icode)
            4'h2: v = E_valA;
            4'h3: v = E_valC;
            4'h4, 4'h5: v = E_valB + E_valC;
            4'h8, 4'hA: v = E_valB - 64'd8;
            4'h9, 4'hB: v = E_valB + 64'd8;
            4'h6: begin
                sa = $signed(E_valA);
                sb = $signed(E_valB);
                case (E_ifun)
                    4'h0: begin v = E_valB + E_valA; tr = sb + sa; of = (tr != $signed(v)); end
                    4'h1: begin v = E_valB - E_valA; tr = sb - sa; of = (tr != $signed(v)); end
                    4'h2: v = E_valB & E_valA;
                    4'h3: v = E_valB ^ E_valA;
                    default: v = 64'd0;
                endcase
            end
            default: v = 64'd0;
        endcase
        zf = (v == 64'd0);
        sf = ($signed(v) < 0);
        flags = {zf, sf, of};
        case (E_ifun)
            4'h0: c = 1'b1;
            4'h1: c = (mcc[1] != mcc[0]) || mcc[2];
            4'h2: c = (mcc[1] != mcc[0]);
            4'h3: c = mcc[2];
            4'h4: c = !mcc[2];
            4'h5: c = (mcc[1] == mcc[0]);
            4'h6: c = (mcc[1] == mcc[0]) && !mcc[2];
            default: c = 1'b0;
        endcase
        d = (E_icode == 4'h2 && !c) ? 4'hF : E_dstE;
        upd = (E_icode == 4'h6) && (E_ifun < 4) && (E_stat == 4'h1) &&
              !set_cc_block && !M_stall && !M_bubble;
    endfunction

    always @(posedge clk or posedge rst) begin
        logic [63:0] v; logic c, u; logic [3:0] d; logic [2:0] f;
        if (rst) begin
            mcc <= 3'b100;
            {mstat, micode, mcnd, mvalE, mvalA, mdstE, mdstM} <= {4'h1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
        end else begin
            model_exec(v, c, d, f, u);
            if (u) mcc <= f;
            if (M_stall) ;
            else if (M_bubble)
                {mstat, micode, mcnd, mvalE, mvalA, mdstE, mdstM} <= {4'h1, 4'h1, 1'b0, 64'd0, 64'd0, 4'hF, 4'hF};
            else
                {mstat, micode, mcnd, mvalE, mvalA, mdstE, mdstM} <= {E_stat, E_icode, c, v, E_valA, d, E_dstM};
        end
    end

    // Per-cycle comparison of every output against the model
    always @(negedge clk) begin
        logic [63:0] v; logic c, u; logic [3:0] d; logic [2:0] f;
        if (run && !rst) begin
            model_exec(v, c, d, f, u);
            check("e_valE", e_valE, v);
            check("e_cnd", 64'(e_cnd), 64'(c));
            check("e_dstE", 64'(e_dstE), 64'(d));
            check("cc", 64'(cc), 64'(mcc));
            check("M_stat", 64'(M_stat), 64'(mstat));
            check("M_icode", 64'(M_icode), 64'(micode));
            check("M_cnd", 64'(M_cnd), 64'(mcnd));
            check("M_valE", M_valE, mvalE);
            check("M_valA", M_valA, mvalA);
            check("M_dstE", 64'(M_dstE), 64'(mdstE));
            check("M_dstM", 64'(M_dstM), 64'(mdstM));
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic issue(input logic [3:0] st, input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] cv,
                         input logic [3:0] de);
        E_stat = st; E_icode = ic; E_ifun = fn;
        E_valA = a; E_valB = b; E_valC = cv; E_dstE = de; E_dstM = 4'hF;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    initial begin
        rst = 1'b1;
        set_cc_block = 1'b0; M_stall = 1'b0; M_bubble = 1'b0;
        issue(4'h1, 4'h1, 4'h0, 64'd0, 64'd0, 64'd0, 4'hF);
        tick(); tick();
        check("rst_cc", 64'(cc), 64'h4);
        check("rst_M_icode", 64'(M_icode), 64'h1);
        check("rst_M_stat", 64'(M_stat), 64'h1);
        check("rst_M_dstE", 64'(M_dstE), 64'hF);
        rst = 1'b0;
        run = 1'b1;

        issue(4'h1, 4'h6, 4'h0, 64'd30, 64'd50, 64'd0, 4'h3);
        check("add_e_valE", e_valE, 64'd80);
        tick();
        check("add_M_valE", M_valE, 64'd80);
        check("add_cc", 64'(cc), 64'h0);

        issue(4'h1, 4'h6, 4'h1, 64'd50, 64'd30, 64'd0, 4'h3);
        check("sub_e_valE", e_valE, 64'hFFFF_FFFF_FFFF_FFEC);
        tick();
        check("sub_cc", 64'(cc), 64'h2);

        issue(4'h1, 4'h6, 4'h1, 64'd30, 64'd30, 64'd0, 4'h3);
        tick();
        check("subz_M_valE", M_valE, 64'd0);
        check("subz_cc", 64'(cc), 64'h4);

        issue(4'h1, 4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 64'd0, 4'h3);
        check("ovf_e_valE", e_valE, 64'h8000_0000_0000_0000);
        tick();
        check("ovf_cc", 64'(cc), 64'h3);

        issue(4'h1, 4'h2, 4'h1, 64'd5, 64'd0, 64'd0, 4'h3);
        check("cmovle_cnd", 64'(e_cnd), 64'h0);
        tick();
        check("cmovle_M_dstE", 64'(M_dstE), 64'hF);

        issue(4'h1, 4'h2, 4'h2, 64'd5, 64'd0, 64'd0, 4'h3);
        check("cmovl_cnd", 64'(e_cnd), 64'h0);
        tick();

        issue(4'h1, 4'h2, 4'h6, 64'd5, 64'd0, 64'd0, 4'h3);
        check("cmovg_cnd", 64'(e_cnd), 64'h1);
        tick();
        check("cmovg_M_dstE", 64'(M_dstE), 64'h3);
        check("cmovg_M_valE", M_valE, 64'd5);

        issue(4'h1, 4'hA, 4'h0, 64'd0, 64'h100, 64'd0, 4'h4);
        tick();
        check("push_M_valE", M_valE, 64'hF8);
        issue(4'h1, 4'hB, 4'h0, 64'd0, 64'hF8, 64'd0, 4'h4);
        tick();
        check("pop_M_valE", M_valE, 64'h100);
        check("pop_cc", 64'(cc), 64'h3);
        issue(4'h1, 4'h3, 4'h0, 64'd0, 64'd99, 64'd20, 4'h2);
        tick();
        check("irmov_M_valE", M_valE, 64'd20);
        issue(4'h1, 4'h4, 4'h0, 64'd7, 64'd50, 64'd35, 4'hF);
        tick();
        check("rmmov_M_valE", M_valE, 64'd85);

        set_cc_block = 1'b1;
        issue(4'h1, 4'h6, 4'h0, 64'd1, 64'd1, 64'd0, 4'h3);
        tick();
        set_cc_block = 1'b0;
        check("blk_M_valE", M_valE, 64'd2);
        check("blk_cc", 64'(cc), 64'h3);

        M_stall = 1'b1;
        issue(4'h1, 4'h6, 4'h0, 64'd0, 64'd0, 64'd0, 4'h5);
        tick();
        check("stall_M_valE", M_valE, 64'd2);
        check("stall_M_dstE", 64'(M_dstE), 64'h3);
        check("stall_cc", 64'(cc), 64'h3);
        M_bubble = 1'b1;
        tick();
        check("stallbub_M_icode", 64'(M_icode), 64'h6);
        M_stall = 1'b0;
        tick();
        M_bubble = 1'b0;
        check("bub_M_icode", 64'(M_icode), 64'h1);
        check("bub_M_dstE", 64'(M_dstE), 64'hF);
        check("bub_cc", 64'(cc), 64'h3);

        issue(4'h1, 4'h6, 4'h0, 64'h7FFF_FFFF, 64'd1, 64'd0, 4'h3);
        tick();
        check("w64_cc", 64'(cc), 64'h0);
        check("w32_cc", 64'(n_cc), 64'h3);
        check("w32_M_valE", 64'(nM_valE), 64'h8000_0000);

        issue(4'h1, 4'h6, 4'h5, 64'd1, 64'd2, 64'd0, 4'h3);
        check("badfn_e_valE", e_valE, 64'd0);
        tick();
        check("badfn_cc", 64'(cc), 64'h0);

        issue(4'h3, 4'h6, 4'h1, 64'd5, 64'd5, 64'd0, 4'h3);
        tick();
        check("exc_cc", 64'(cc), 64'h0);
        check("exc_M_stat", 64'(M_stat), 64'h3);

        #1 rst = 1'b1;
        #1;
        check("midrst_cc", 64'(cc), 64'h4);
        check("midrst_M_icode", 64'(M_icode), 64'h1);
        check("midrst_M_stat", 64'(M_stat), 64'h1);
        #5 rst = 1'b0;
        tick();
        issue(4'h1, 4'h6, 4'h0, 64'd2, 64'd3, 64'd0, 4'h3);
        tick();
        check("postrst_M_valE", M_valE, 64'd5);
        check("postrst_cc", 64'(cc), 64'h0);

        tick();
        run = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
